// File: rtl/vending_pkg.sv
// Shared definitions for the multi-product vending controller.
//   - FSM state encodings for the top-level controller and the change dispenser
//   - coin code constants
//   - coin_value(): value of a coin code given the configured denominations
//   - greedy_coin(): largest coin whose value fits in an amount
package vending_pkg;

  // Controller states
  typedef logic [1:0] state_t;
  localparam state_t ST_COLLECT = 2'd0;
  localparam state_t ST_VEND    = 2'd1;
  localparam state_t ST_CHANGE  = 2'd2;

  // Change dispenser states
  typedef logic ds_state_t;
  localparam ds_state_t DS_IDLE = 1'b0;
  localparam ds_state_t DS_RUN  = 1'b1;

  // Coin codes, shared by the acceptor input and the return output
  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_1    = 2'b01;
  localparam logic [1:0] COIN_2    = 2'b10;
  localparam logic [1:0] COIN_3    = 2'b11;

  // Denomination values, bundled so helpers stay parameter-agnostic
  typedef struct packed {
    logic [31:0] v3;
    logic [31:0] v2;
    logic [31:0] v1;
  } coin_vals_t;

  function automatic logic [31:0] coin_value(input logic [1:0] code,
                                             input coin_vals_t vals);
    case (code)
      COIN_1:  return vals.v1;
      COIN_2:  return vals.v2;
      COIN_3:  return vals.v3;
      default: return 32'd0;
    endcase
  endfunction

  // Largest-first selection; COIN_NONE when even the smallest coin does not fit
  function automatic logic [1:0] greedy_coin(input logic [31:0] amt,
                                             input coin_vals_t vals);
    if (amt >= vals.v3)      return COIN_3;
    else if (amt >= vals.v2) return COIN_2;
    else if (amt >= vals.v1) return COIN_1;
    else                     return COIN_NONE;
  endfunction

endpackage

// File: rtl/vending_change_dispenser.sv
// Greedy change dispenser: returns an amount one coin per cycle, largest first.
//
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   load            start returning load_amt (only honoured when idle)
//   load_amt        amount to return
//   change_valid    registered: one coin returned this cycle
//   change          registered: coin code, valid with change_valid
//   take_val        combinational: value committed to the coin being issued
//                   at the coming edge (0 when none); the owner subtracts this
//                   from its credit so credit tracks the remaining amount
//   remaining       amount still owed after the coins already issued
//   ds_state        dispenser FSM state (DS_IDLE / DS_RUN), for observation
//
// The first coin is issued on the same edge that loads the amount, so a
// load in cycle N shows its first coin in cycle N+1. After the last coin the
// dispenser spends one cycle in DS_RUN with remaining==0 (the "done" cycle)
// before returning to DS_IDLE.
module vending_change_dispenser
  import vending_pkg::*;
#(
  parameter int unsigned CREDIT_W  = 8,
  parameter int unsigned COIN1_VAL = 5,
  parameter int unsigned COIN2_VAL = 10,
  parameter int unsigned COIN3_VAL = 25
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic [CREDIT_W-1:0] load_amt,
  output logic                change_valid,
  output logic [1:0]          change,
  output logic [CREDIT_W-1:0] take_val,
  output logic [CREDIT_W-1:0] remaining,
  output logic                ds_state
);

  localparam coin_vals_t VALS = '{v3: 32'(COIN3_VAL), v2: 32'(COIN2_VAL),
                                  v1: 32'(COIN1_VAL)};

  ds_state_t           ds_state_q, ds_state_d;
  logic [CREDIT_W-1:0] remaining_q, remaining_d;
  logic                change_valid_q, change_valid_d;
  logic [1:0]          change_q, change_d;

  logic [CREDIT_W-1:0] src;
  logic                emit;
  logic [1:0]          pick;

  always_comb begin
    ds_state_d     = ds_state_q;
    remaining_d    = remaining_q;
    change_valid_d = 1'b0;
    change_d       = COIN_NONE;
    take_val       = '0;
    src            = '0;
    emit           = 1'b0;
    pick           = COIN_NONE;

    if (ds_state_q == DS_IDLE) begin
      if (load && (load_amt != '0)) begin
        src        = load_amt;
        emit       = 1'b1;
        ds_state_d = DS_RUN;
      end
    end else if (remaining_q == '0) begin
      ds_state_d = DS_IDLE;
    end else begin
      src  = remaining_q;
      emit = 1'b1;
    end

    if (emit) begin
      pick           = greedy_coin(32'(src), VALS);
      take_val       = CREDIT_W'(coin_value(pick, VALS));
      change_valid_d = (pick != COIN_NONE);
      change_d       = pick;
      // An amount below the smallest coin cannot occur with exact-change
      // configurations; drop it rather than stall forever.
      remaining_d    = (pick == COIN_NONE) ? '0 : (src - take_val);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ds_state_q     <= DS_IDLE;
      remaining_q    <= '0;
      change_valid_q <= 1'b0;
      change_q       <= COIN_NONE;
    end else begin
      ds_state_q     <= ds_state_d;
      remaining_q    <= remaining_d;
      change_valid_q <= change_valid_d;
      change_q       <= change_d;
    end
  end

  assign change_valid = change_valid_q;
  assign change       = change_q;
  assign remaining    = remaining_q;
  assign ds_state     = ds_state_q;

endmodule

// File: rtl/vending_machine_multi.sv
// Multi-product vending controller.
//
// Accepts three coin denominations into a credit register, vends one of
// NUM_ITEMS products at per-item prices, supports cancel/refund, and returns
// change one coin per cycle (greedy, largest first) via
// vending_change_dispenser.
//
// Ports:
//   clk, reset     clock; synchronous active-high reset (highest priority)
//   money          coin code from the acceptor (00 none, 01/10/11 coins)
//   sel_valid      product select strobe, sel_id the product index
//   cancel         refund request
//   out, out_id    one-cycle dispense pulse and product index
//   change_valid   one coin returned this cycle, change = coin code
//   coin_reject    inserted coin bounced back this cycle
//   deny           select refused (low credit, bad id, sold out)
//   credit         current credit
//   busy           high while vending or returning change
//   sold_out       per-item empty flags
//
// Handshake: all inputs are sampled on the rising edge; every output is a
// register, and the pulse outputs (out, change_valid, coin_reject, deny) are
// high for exactly one cycle per event. No backpressure exists.
//
// Priority in COLLECT: cancel (with credit) > sel_valid > money. A coin that
// arrives with an accepted cancel or select is bounced; with a refused
// select it is handled as a lone coin.
//
// Optional feature macro: VEND_STOCK_EN adds per-item stock counters loaded
// with STOCK_INIT at reset; without it stock is unlimited and sold_out is 0.
module vending_machine_multi
  import vending_pkg::*;
#(
  parameter int unsigned NUM_ITEMS  = 4,
  parameter int unsigned CREDIT_W   = 8,
  parameter logic [NUM_ITEMS*CREDIT_W-1:0] PRICES = 32'h1E19_140F,
  parameter int unsigned COIN1_VAL  = 5,
  parameter int unsigned COIN2_VAL  = 10,
  parameter int unsigned COIN3_VAL  = 25,
  parameter int unsigned MAX_CREDIT = 95,
  parameter int unsigned STOCK_INIT = 3,
  localparam int unsigned ID_W = (NUM_ITEMS > 1) ? $clog2(NUM_ITEMS) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [1:0]           money,
  input  logic                 sel_valid,
  input  logic [ID_W-1:0]      sel_id,
  input  logic                 cancel,
  output logic                 out,
  output logic [ID_W-1:0]      out_id,
  output logic                 change_valid,
  output logic [1:0]           change,
  output logic                 coin_reject,
  output logic                 deny,
  output logic [CREDIT_W-1:0]  credit,
  output logic                 busy,
  output logic [NUM_ITEMS-1:0] sold_out
);

  localparam coin_vals_t VALS = '{v3: 32'(COIN3_VAL), v2: 32'(COIN2_VAL),
                                  v1: 32'(COIN1_VAL)};

  // Configuration checks: change must always be exact.
  if ((COIN1_VAL == 0) || ((COIN2_VAL % COIN1_VAL) != 0) ||
      ((COIN3_VAL % COIN1_VAL) != 0)) begin : g_bad_coins
    $error("coin values must be nonzero multiples of COIN1_VAL");
  end
  if (MAX_CREDIT >= (64'd1 << CREDIT_W)) begin : g_bad_max
    $error("MAX_CREDIT must fit in CREDIT_W bits");
  end
  for (genvar g = 0; g < NUM_ITEMS; g++) begin : g_price_chk
    if (COIN1_VAL != 0) begin : g_nz
      if (((32'(PRICES[g*CREDIT_W +: CREDIT_W]) + MAX_CREDIT) % COIN1_VAL) != 0)
      begin : g_bad_price
        $error("price plus MAX_CREDIT must be a multiple of COIN1_VAL");
      end
    end
  end

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  state_t              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic                out_q, out_d;
  logic [ID_W-1:0]     out_id_q, out_id_d;
  logic                coin_reject_q, coin_reject_d;
  logic                deny_q, deny_d;
  logic                busy_q, busy_d;

  // Dispenser interface
  logic                ds_load;
  logic [CREDIT_W-1:0] ds_load_amt;
  logic [CREDIT_W-1:0] ds_take_val;
  logic [CREDIT_W-1:0] ds_remaining;
  logic                ds_state;
  logic                ds_done;

  // Selection decode
  logic                sel_ok;
  logic [CREDIT_W-1:0] sel_price;
  logic                sel_empty;
  logic [NUM_ITEMS-1:0] item_empty;

  // Coin decode; the sum carries one spare bit so it never wraps
  logic                coin_in;
  logic [CREDIT_W-1:0] coin_val;
  logic [CREDIT_W:0]   coin_sum;

  assign coin_in  = (money != COIN_NONE);
  assign coin_val = CREDIT_W'(coin_value(money, VALS));
  assign coin_sum = {1'b0, credit_q} + {1'b0, coin_val};

  // The loop keeps an out-of-range sel_id from indexing past PRICES.
  always_comb begin
    sel_ok    = 1'b0;
    sel_price = '0;
    sel_empty = 1'b0;
    for (int i = 0; i < NUM_ITEMS; i++) begin
      if (sel_id == ID_W'(i)) begin
        sel_ok    = 1'b1;
        sel_price = PRICES[i*CREDIT_W +: CREDIT_W];
        sel_empty = item_empty[i];
      end
    end
  end

  // Refund starts either from cancel in COLLECT or after a vend that
  // leaves credit; the whole credit is handed to the dispenser.
  assign ds_load = (credit_q != '0) &&
                   (((state_q == ST_COLLECT) && cancel) || (state_q == ST_VEND));
  assign ds_load_amt = credit_q;
  assign ds_done = (ds_state == DS_RUN) && (ds_remaining == '0);

  vending_change_dispenser #(
    .CREDIT_W  (CREDIT_W),
    .COIN1_VAL (COIN1_VAL),
    .COIN2_VAL (COIN2_VAL),
    .COIN3_VAL (COIN3_VAL)
  ) u_change (
    .clk          (clk),
    .reset        (reset),
    .load         (ds_load),
    .load_amt     (ds_load_amt),
    .change_valid (change_valid),
    .change       (change),
    .take_val     (ds_take_val),
    .remaining    (ds_remaining),
    .ds_state     (ds_state)
  );

  // ---------------------------------------------------------------------
  // Controller next-state
  // ---------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    credit_d      = credit_q;
    out_d         = 1'b0;
    out_id_d      = '0;
    coin_reject_d = 1'b0;
    deny_d        = 1'b0;

    case (state_q)
      ST_COLLECT: begin
        if (cancel && (credit_q != '0)) begin
          state_d       = ST_CHANGE;
          credit_d      = credit_q - ds_take_val;
          coin_reject_d = coin_in;
        end else if (sel_valid && sel_ok && (credit_q >= sel_price) && !sel_empty) begin
          state_d       = ST_VEND;
          out_d         = 1'b1;
          out_id_d      = sel_id;
          credit_d      = credit_q - sel_price;
          coin_reject_d = coin_in;
        end else begin
          deny_d = sel_valid;
          if (coin_in) begin
            if (coin_sum <= (CREDIT_W+1)'(MAX_CREDIT)) begin
              credit_d = coin_sum[CREDIT_W-1:0];
            end else begin
              coin_reject_d = 1'b1;
            end
          end
        end
      end

      ST_VEND: begin
        coin_reject_d = coin_in;
        if (credit_q != '0) begin
          state_d  = ST_CHANGE;
          credit_d = credit_q - ds_take_val;
        end else begin
          state_d = ST_COLLECT;
        end
      end

      ST_CHANGE: begin
        coin_reject_d = coin_in;
        credit_d      = credit_q - ds_take_val;
        if (ds_done) begin
          state_d = ST_COLLECT;
        end
      end

      default: state_d = ST_COLLECT;
    endcase

    busy_d = (state_d != ST_COLLECT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_COLLECT;
      credit_q      <= '0;
      out_q         <= 1'b0;
      out_id_q      <= '0;
      coin_reject_q <= 1'b0;
      deny_q        <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      credit_q      <= credit_d;
      out_q         <= out_d;
      out_id_q      <= out_id_d;
      coin_reject_q <= coin_reject_d;
      deny_q        <= deny_d;
      busy_q        <= busy_d;
    end
  end

  // ---------------------------------------------------------------------
  // Stock tracking
  // ---------------------------------------------------------------------
`ifdef VEND_STOCK_EN
  localparam int unsigned STOCK_W = (STOCK_INIT > 0) ? $clog2(STOCK_INIT + 1) : 1;

  logic [STOCK_W-1:0]   stock_q [NUM_ITEMS];
  logic [STOCK_W-1:0]   stock_d [NUM_ITEMS];
  logic [NUM_ITEMS-1:0] sold_out_q;

  // A vend is only accepted for a non-empty item, so no underflow.
  always_comb begin
    for (int i = 0; i < NUM_ITEMS; i++) begin
      stock_d[i]    = stock_q[i];
      item_empty[i] = (stock_q[i] == '0);
      if (out_d && (out_id_d == ID_W'(i))) begin
        stock_d[i] = stock_q[i] - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_ITEMS; i++) begin
        stock_q[i] <= STOCK_W'(STOCK_INIT);
      end
      sold_out_q <= '0;
    end else begin
      for (int i = 0; i < NUM_ITEMS; i++) begin
        stock_q[i]    <= stock_d[i];
        sold_out_q[i] <= (stock_d[i] == '0);
      end
    end
  end

  assign sold_out = sold_out_q;
`else
  assign item_empty = '0;
  assign sold_out   = '0;
`endif

  assign out         = out_q;
  assign out_id      = out_id_q;
  assign coin_reject = coin_reject_q;
  assign deny        = deny_q;
  assign credit      = credit_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_vending_machine_multi.sv
// Testbench for vending_machine_multi: directed scenarios followed by
// randomized traffic, checked by a scoreboard fed from a behavioural model.
module tb_vending_machine_multi;

  // ---------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------
  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] money;
  logic       sel_valid;
  logic [1:0] sel_id;
  logic       cancel;
  logic       out;
  logic [1:0] out_id;
  logic       change_valid;
  logic [1:0] change;
  logic       coin_reject;
  logic       deny;
  logic [7:0] credit;
  logic       busy;
  logic [3:0] sold_out;

  always #5 clk = ~clk;

  vending_machine_multi dut (
    .clk          (clk),
    .reset        (reset),
    .money        (money),
    .sel_valid    (sel_valid),
    .sel_id       (sel_id),
    .cancel       (cancel),
    .out          (out),
    .out_id       (out_id),
    .change_valid (change_valid),
    .change       (change),
    .coin_reject  (coin_reject),
    .deny         (deny),
    .credit       (credit),
    .busy         (busy),
    .sold_out     (sold_out)
  );

  // ---------------------------------------------------------------------
  // Scoreboard bookkeeping
  // ---------------------------------------------------------------------
  localparam int W = 21;
  int total = 0;
  int bad   = 0;
  logic [W-1:0] exp_q[$];

  function automatic logic [W-1:0] pack(input logic o, input logic [1:0] id,
      input logic cv, input logic [1:0] ch, input logic dn, input logic rj,
      input logic [7:0] cr, input logic bz, input logic [3:0] so);
    return {o, id, cv, ch, dn, rj, cr, bz, so};
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  // ---------------------------------------------------------------------
  // Behavioural reference model: credit as an integer, a mode label, and
  // the pending refund as a list of coins computed up front.
  // ---------------------------------------------------------------------
  localparam int M_COLLECT = 0;
  localparam int M_VEND    = 1;
  localparam int M_CHANGE  = 2;

  int prices[4] = '{15, 20, 25, 30};
  int m_credit;
  int m_mode;
  int m_coins[$];
  int m_stock[4];

  function automatic int val_of(input int code);
    case (code)
      1: return 5;
      2: return 10;
      3: return 25;
      default: return 0;
    endcase
  endfunction

  function automatic logic [3:0] m_sold();
    logic [3:0] s;
    s = '0;
`ifdef VEND_STOCK_EN
    for (int i = 0; i < 4; i++) s[i] = (m_stock[i] == 0);
`endif
    return s;
  endfunction

  function automatic bit m_in_stock(input int id);
`ifdef VEND_STOCK_EN
    return m_stock[id] > 0;
`else
    return 1'b1;
`endif
  endfunction

  task automatic m_plan_refund();
    int rem;
    rem = m_credit;
    m_coins.delete();
    while (rem >= 25) begin m_coins.push_back(3); rem -= 25; end
    while (rem >= 10) begin m_coins.push_back(2); rem -= 10; end
    while (rem >= 5)  begin m_coins.push_back(1); rem -= 5;  end
  endtask

  // Advances the model by one clock edge with the given inputs and queues
  // the expected output snapshot if any pulse is due.
  task automatic m_step(input int mo, input bit sv, input int sid,
                        input bit cn, input bit rs);
    logic e_out, e_cv, e_deny, e_rej;
    logic [1:0] e_id, e_ch;
    bit emit;
    int c;
    e_out = 0; e_cv = 0; e_deny = 0; e_rej = 0; e_id = 0; e_ch = 0;
    emit = 0;
    if (rs) begin
      m_credit = 0;
      m_mode   = M_COLLECT;
      m_coins.delete();
      for (int i = 0; i < 4; i++) m_stock[i] = 3;
      return;
    end
    case (m_mode)
      M_COLLECT: begin
        if (cn && m_credit > 0) begin
          m_plan_refund();
          emit  = 1;
          e_rej = (mo != 0);
        end else if (sv && prices[sid] <= m_credit && m_in_stock(sid)) begin
          e_out = 1;
          e_id  = 2'(sid);
          m_credit -= prices[sid];
          m_stock[sid]--;
          m_mode = M_VEND;
          e_rej  = (mo != 0);
        end else begin
          e_deny = sv;
          if (mo != 0) begin
            if (m_credit + val_of(mo) <= 95) m_credit += val_of(mo);
            else e_rej = 1;
          end
        end
      end
      M_VEND: begin
        e_rej = (mo != 0);
        if (m_credit > 0) begin
          m_plan_refund();
          emit = 1;
        end else begin
          m_mode = M_COLLECT;
        end
      end
      default: begin
        e_rej = (mo != 0);
        if (m_coins.size() > 0) emit = 1;
        else m_mode = M_COLLECT;
      end
    endcase
    if (emit) begin
      c = m_coins.pop_front();
      e_cv = 1;
      e_ch = 2'(c);
      m_credit -= val_of(c);
      m_mode = M_CHANGE;
    end
    if (e_out || e_cv || e_deny || e_rej)
      exp_q.push_back(pack(e_out, e_id, e_cv, e_ch, e_deny, e_rej,
                           8'(m_credit), (m_mode != M_COLLECT), m_sold()));
  endtask

  // ---------------------------------------------------------------------
  // Monitor: compares every cycle in which the DUT shows a pulse
  // ---------------------------------------------------------------------
  always @(negedge clk) begin
    logic [W-1:0] act;
    logic [W-1:0] e;
    if (out === 1'b1 || change_valid === 1'b1 || deny === 1'b1 || coin_reject === 1'b1) begin
      act = pack(out, out ? out_id : 2'b00, change_valid,
                 change_valid ? change : 2'b00, deny, coin_reject,
                 credit, busy, sold_out);
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_event: got %h expected none", act);
      end else begin
        e = exp_q.pop_front();
        if (act !== e) begin
          bad++;
          $display("FAIL event: got %h expected %h", act, e);
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // Driver
  // ---------------------------------------------------------------------
  task automatic cyc(input logic [1:0] mo, input logic sv, input logic [1:0] sid,
                     input logic cn, input logic rs);
    money = mo; sel_valid = sv; sel_id = sid; cancel = cn; reset = rs;
    @(posedge clk);
    m_step(mo, sv, sid, cn, rs);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(2'b00, 0, 2'd0, 0, 0);
  endtask

  task automatic coin(input logic [1:0] mo);
    cyc(mo, 0, 2'd0, 0, 0);
  endtask

  // ---------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------
  initial begin
    money = 0; sel_valid = 0; sel_id = 0; cancel = 0; reset = 1;
    m_credit = 0; m_mode = M_COLLECT;
    for (int i = 0; i < 4; i++) m_stock[i] = 3;

    cyc(2'b00, 0, 2'd0, 0, 1);
    cyc(2'b00, 0, 2'd0, 0, 1);
    check("reset_credit", credit, 0);
    check("reset_out", {out, change_valid, coin_reject, deny, busy}, 0);
    check("reset_sold_out", sold_out, 0);

    // Exact payment, no change
    coin(2'b01); check("credit_5", credit, 5);
    coin(2'b01); check("credit_10", credit, 10);
    coin(2'b01); check("credit_15", credit, 15);
    cyc(2'b00, 1, 2'd0, 0, 0);
    check("vend0_out", out, 1);
    check("vend0_id", out_id, 0);
    check("vend0_credit", credit, 0);
    idle(1);
    check("vend0_no_change", change_valid, 0);
    check("vend0_idle", busy, 0);

    // 25 paid for a 15 item: one 10 back
    coin(2'b11);
    cyc(2'b00, 1, 2'd0, 0, 0);
    check("vend_chg_out", out, 1);
    idle(1);
    check("chg10_valid", change_valid, 1);
    check("chg10_code", change, 2'b10);
    check("chg10_credit", credit, 0);
    idle(1);
    check("chg10_single", change_valid, 0);
    check("chg10_back", busy, 0);

    // 75 then cancel: three 25s back to back
    coin(2'b11); coin(2'b11); coin(2'b11);
    check("credit_75", credit, 75);
    cyc(2'b00, 0, 2'd0, 1, 0);
    check("cancel_c1", {change_valid, change}, 3'b111);
    check("cancel_cr1", credit, 50);
    idle(1);
    check("cancel_c2", {change_valid, change}, 3'b111);
    idle(1);
    check("cancel_c3", {change_valid, change}, 3'b111);
    check("cancel_cr3", credit, 0);
    idle(1);
    check("cancel_done", {change_valid, busy}, 0);

    // Ceiling: 90 + 10 bounces
    coin(2'b11); coin(2'b11); coin(2'b11); coin(2'b10); coin(2'b01);
    check("credit_90", credit, 90);
    coin(2'b10);
    check("max_reject", coin_reject, 1);
    check("max_credit_kept", credit, 90);
    cyc(2'b00, 0, 2'd0, 1, 0);
    idle(7);

    // Insufficient credit
    coin(2'b10); coin(2'b01);
    cyc(2'b00, 1, 2'd1, 0, 0);
    check("deny_low", deny, 1);
    check("deny_credit", credit, 15);
    cyc(2'b00, 0, 2'd0, 1, 0);
    idle(3);

    // Coin together with cancel
    coin(2'b10);
    cyc(2'b01, 0, 2'd0, 1, 0);
    check("cancel_coin_rej", coin_reject, 1);
    check("cancel_coin_chg", {change_valid, change}, 3'b110);
    idle(2);

    // Reset during refund
    coin(2'b11); coin(2'b11);
    cyc(2'b00, 0, 2'd0, 1, 0);
    check("pre_reset_chg", change_valid, 1);
    cyc(2'b00, 0, 2'd0, 0, 1);
    check("mid_reset_outs", {change_valid, busy, out}, 0);
    check("mid_reset_credit", credit, 0);
    idle(1);
    check("post_reset_quiet", change_valid, 0);

`ifdef VEND_STOCK_EN
    for (int k = 0; k < 4; k++) begin
      coin(2'b11);
      cyc(2'b00, 1, 2'd2, 0, 0);
      if (k < 3) check("stock_vend", out, 1);
      else begin
        check("stock_deny", deny, 1);
        check("stock_credit_kept", credit, 25);
      end
      if (k == 2) check("stock_sold_out", sold_out[2], 1);
      idle(1);
    end
    cyc(2'b00, 0, 2'd0, 1, 0);
    idle(3);
`endif

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      logic [1:0] mo;
      mo = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      cyc(mo, ($urandom_range(0, 5) == 0), 2'($urandom_range(0, 3)),
          ($urandom_range(0, 24) == 0), ($urandom_range(0, 299) == 0));
    end

    idle(10);
    check("queue_drained", exp_q.size(), 0);
    check("final_credit_vs_model", credit, m_credit);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vending_machine_multi.md
Name: vending_machine_multi

Overview:
Parametrised multi-product vending controller, successor to the single-product 15-unit vending FSM. Accepts three coin denominations and accumulates credit. Serves one of NUM_ITEMS products with per-item prices, supports cancel/refund, and returns change sequentially, one coin per cycle, using greedy largest-first selection. Sits between the coin acceptor, the keypad decoder and the dispense/coin-return actuators.

Parameters:
NUM_ITEMS, 4, number of selectable products
CREDIT_W, 8, width of credit/price arithmetic
PRICES, 32'h1E19_140F, packed NUM_ITEMS*CREDIT_W item prices, item 0 in LSBs (15,20,25,30)
COIN1_VAL, 5, value of coin code 2'b01
COIN2_VAL, 10, value of coin code 2'b10
COIN3_VAL, 25, value of coin code 2'b11
MAX_CREDIT, 95, credit ceiling; must be < 2**CREDIT_W
STOCK_INIT, 3, per-item stock after reset (VEND_STOCK_EN only)

Ports:
clk  in  1  clock, all state changes on rising edge
reset  in  1  synchronous, active-high
money  in  2  coin code: 00 none, 01/10/11 = COIN1/2/3
sel_valid  in  1  product select strobe
sel_id  in  $clog2(NUM_ITEMS)  selected product index
cancel  in  1  refund request
out  out  1  one-cycle dispense pulse
out_id  out  $clog2(NUM_ITEMS)  product dispensed, valid with out
change_valid  out  1  one coin returned this cycle
change  out  2  coin code returned, valid with change_valid
coin_reject  out  1  inserted coin bounced back this cycle
deny  out  1  select refused (insufficient credit, bad id, sold out)
credit  out  CREDIT_W  current accumulated credit
busy  out  1  high in VEND/CHANGE
sold_out  out  NUM_ITEMS  per-item empty flags

Behaviour:
- Reset (sync, active-high, priority over everything): state COLLECT; credit=0; out, out_id, change_valid, change, coin_reject, deny, busy = 0; stock = STOCK_INIT; sold_out = 0.
- All outputs are registered. Pulses last exactly one cycle.
- States: COLLECT, VEND, CHANGE.
- COLLECT, per-cycle priority is cancel > sel_valid > money:
  - cancel with credit>0 -> CHANGE, remaining=credit. cancel with credit=0 -> no-op.
  - sel_valid: accept when sel_id<NUM_ITEMS, credit>=PRICES[sel_id], and not sold out. On accept -> VEND next cycle: out=1, out_id=sel_id, credit-=price. On refuse -> deny=1 next cycle, state unchanged.
  - A coin arriving in the same cycle as an accepted cancel or select is rejected (coin_reject=1).
  - A coin alone: if credit+value<=MAX_CREDIT, credit+=value next cycle; else coin_reject=1 and credit unchanged. Compute the sum at CREDIT_W+1 bits; no wrap-around.
- VEND (1 cycle): -> CHANGE if credit>0, else COLLECT.
- CHANGE, one coin per cycle: pick the largest value <= remaining (COIN3, then 2, then 1). Set change_valid=1 and change=code; remaining and credit decrease by that value. -> COLLECT on the cycle remaining reaches 0.
- Any coin offered during VEND or CHANGE is rejected. sel_valid and cancel are ignored there, with no deny.
- Change is always exact: an elaboration-time check requires COIN2_VAL and COIN3_VAL to be multiples of COIN1_VAL, and every price plus MAX_CREDIT to be a multiple of COIN1_VAL.
- Reset asserted mid-CHANGE: remaining credit is discarded and no further coins are returned.
- Latency: select edge N -> out at N+1 -> first change coin at N+2.

Optional Feature:
VEND_STOCK_EN.
- Defined: per-item stock counters load STOCK_INIT at reset and decrement on each vend. sold_out[i]=1 when the count is 0. Selecting a sold-out item -> deny; credit is kept.
- Undefined: stock is unlimited, sold_out tied to 0, no counters synthesised.

Decomposition:
- Package vending_pkg holds:
  - the state enum (COLLECT, VEND, CHANGE);
  - coin code constants (COIN_NONE, COIN_1, COIN_2, COIN_3);
  - a function coin_value(code, vals) returning the value of a coin code.
- Sub-module vending_change_dispenser owns the greedy change FSM (load, remaining, one coin per cycle, done). It is instantiated once.

Test Plan:
- Coins 01,01,01 then sel_id=0 -> credit 5,10,15; out=1 with out_id=0; credit 0; no change_valid.
- Coin 11 (25) then sel_id=0 (15) -> out, then change_valid with change=10 for one cycle; back to COLLECT with credit 0.
- Coins 11,11,11 (75) then cancel -> change 11,11,11 on three consecutive cycles; credit 0.
- Credit 90 then coin 10 -> coin_reject=1, credit stays 90. sel_id=1 with credit 15 -> deny=1, credit 15.
- Same-cycle cancel+coin with credit 10 -> coin_reject=1, one change=10. Reset asserted mid-CHANGE -> outputs 0 next cycle, credit 0.
- VEND_STOCK_EN: four vends of item 2 -> the fourth gets deny; sold_out[2]=1 after the third vend.
